ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Purpose : RV32I(+M) decode, ID/EX control register, load-use and MUL/DIV stall control.
// Latency : one cycle from ID inputs to o_ex_*; o_stall is combinational.
// Backpr. : o_stall holds PC and IF/ID; ID/EX injects a bubble (load-use) or holds (MUL/DIV busy).
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_id_valid, i_opcode,
//   i_funct3, i_funct7,
//   i_rs1, i_rs2, i_rd         ID-stage instruction fields
//   i_flush                    EX redirect, kills ID and EX, overrides both stalls
//   i_md_done                  MUL/DIV result ready (ignored when M_EXT = 0)
//   o_stall                    hold PC and IF/ID this cycle
//   o_ex_*                     registered ID/EX control fields
//   o_md_busy                  MUL/DIV FSM in BUSY
//   o_stall_cnt                saturating count of stalled cycles since reset
module ctrl_pipe #(
   parameter int M_EXT = 0,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [6:0]       i_opcode,
   input  logic [2:0]       i_funct3,
   input  logic [6:0]       i_funct7,
   input  logic [4:0]       i_rs1,
   input  logic [4:0]       i_rs2,
   input  logic [4:0]       i_rd,
   input  logic             i_flush,
   input  logic             i_md_done,
   output logic             o_stall,
   output logic             o_ex_valid,
   output logic [2:0]       o_ex_alu_op,
   output logic [1:0]       o_ex_wb_sel,
   output logic [4:0]       o_ex_rd,
   output logic             o_ex_mem_read,
   output logic             o_ex_mem_write,
   output logic             o_ex_reg_write,
   output logic             o_ex_md,
   output logic             o_ex_illegal,
   output logic             o_md_busy,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t state, state_nxt;

   logic [2:0] dec_alu_op;
   logic [1:0] dec_wb_sel;
   logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_md, dec_illegal;
   logic       dec_use_rs1, dec_use_rs2;
   logic       load_use, md_hold, md_enter;

   // Decode of the ID-stage instruction.
   always_comb begin
      dec_alu_op    = 3'b000;
      dec_wb_sel    = 2'b00;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_md        = 1'b0;
      dec_illegal   = 1'b0;
      dec_use_rs1   = 1'b0;
      dec_use_rs2   = 1'b0;
      case (i_opcode)
         OPC_OP: begin
            dec_alu_op    = i_funct3;
            dec_reg_write = 1'b1;
            dec_use_rs1   = 1'b1;
            dec_use_rs2   = 1'b1;
            if (i_funct7 == F7_MULDIV) begin
               if (M_EXT != 0) dec_md      = 1'b1;
               else            dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_alu_op    = i_funct3;
            dec_reg_write = 1'b1;
            dec_use_rs1   = 1'b1;
         end
         OPC_LOAD: begin
            dec_wb_sel    = 2'b10;
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
            dec_use_rs1   = 1'b1;
         end
         OPC_STORE: begin
            dec_mem_write = 1'b1;
            dec_use_rs1   = 1'b1;
            dec_use_rs2   = 1'b1;
         end
         OPC_BRANCH: begin
            dec_use_rs1   = 1'b1;
            dec_use_rs2   = 1'b1;
         end
         OPC_JALR: begin
            dec_wb_sel    = 2'b01;
            dec_reg_write = 1'b1;
            dec_use_rs1   = 1'b1;
         end
         OPC_JAL: begin
            dec_wb_sel    = 2'b01;
            dec_reg_write = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: dec_reg_write = 1'b1;
         OPC_FENCE, OPC_SYSTEM: ;
         default: dec_illegal = 1'b1;
      endcase
      // An illegal instruction must have no architectural side effects.
      if (dec_illegal) begin
         dec_reg_write = 1'b0;
         dec_mem_read  = 1'b0;
         dec_mem_write = 1'b0;
         dec_md        = 1'b0;
      end
   end

   // x0 never carries a dependency, and an invalid ID slot never stalls.
   assign load_use = o_ex_valid && o_ex_mem_read && (o_ex_rd != 5'd0) && i_id_valid &&
                     ((dec_use_rs1 && (i_rs1 == o_ex_rd)) || (dec_use_rs2 && (i_rs2 == o_ex_rd)));

   // A same-cycle done releases the hold so the register advances this edge.
   assign md_hold  = (state == BUSY) && !i_md_done;
   assign md_enter = i_id_valid && dec_md && !load_use;

   assign o_stall   = !i_rst && !i_flush && (md_hold || load_use);
   assign o_md_busy = (state == BUSY);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // BUSY means "EX holds a MUL/DIV still waiting for its result", so BUSY is
   // entered on the same edge that loads the md instruction into EX.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!i_flush && md_enter) state_nxt = BUSY;
         BUSY: begin
            if (i_flush)        state_nxt = IDLE;
            else if (i_md_done) state_nxt = md_enter ? BUSY : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ID/EX register: reset, flush, load-use and invalid ID all load an all-zero bubble.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush || (!md_hold && (load_use || !i_id_valid))) begin
         o_ex_valid     <= 1'b0;
         o_ex_alu_op    <= 3'b000;
         o_ex_wb_sel    <= 2'b00;
         o_ex_rd        <= 5'd0;
         o_ex_mem_read  <= 1'b0;
         o_ex_mem_write <= 1'b0;
         o_ex_reg_write <= 1'b0;
         o_ex_md        <= 1'b0;
         o_ex_illegal   <= 1'b0;
      end else if (!md_hold) begin
         o_ex_valid     <= 1'b1;
         o_ex_alu_op    <= dec_alu_op;
         o_ex_wb_sel    <= dec_wb_sel;
         o_ex_rd        <= i_rd;
         o_ex_mem_read  <= dec_mem_read;
         o_ex_mem_write <= dec_mem_write;
         o_ex_reg_write <= dec_reg_write;
         o_ex_md        <= dec_md;
         o_ex_illegal   <= dec_illegal;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_stall_cnt <= '0;
      else if (o_stall && (o_stall_cnt != {CNT_W{1'b1}}))
         o_stall_cnt <= o_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule
